aux_perf_monitor: RTL
=====================

Name: aux_perf_monitor

Overview:
- Parametrised event-counter bank with a display selector for the board top level; replaces the fixed set of four free-running counters and the hard-coded display mux.
- Counts per-channel core events only on core-step strobes, so each core cycle counts once regardless of the board/core clock ratio.
- Adds wrap/saturate mode, sticky overflow flags, synchronous clear, snapshot freeze and an auto-rotating display channel.
- The output feeds the seven-segment display driver.

Parameters:
- NumChan, 8, number of event channels (2..16)
- CntBit, 32, counter and display data width
- SelBit, 4, channel-select width; must satisfy 2^SelBit >= NumChan
- DwellCnt, 1000, clk cycles each channel stays on display in auto mode (>= 1)
- Saturate, 0, 0 = counters wrap to 0; 1 = counters stick at all-ones

Ports:
- clk, in, 1, board clock; sole clock
- rst, in, 1, asynchronous active-high reset
- step, in, 1, one-clk pulse marking a core clock edge
- evt, in, NumChan, per-channel event levels, sampled only when step=1
- clr, in, 1, synchronous clear of counters, overflow flags and snapshot
- freeze, in, 1, level; while high the display shows the snapshot taken on its rising edge
- mode_auto, in, 1, 1 = rotate display channel; 0 = manual select
- sel, in, SelBit, manual channel select
- disp_data, out, CntBit, registered value of the displayed channel
- disp_chan, out, SelBit, registered index of the displayed channel
- ovf, out, NumChan, sticky per-channel overflow flags

Behaviour:
- Reset (async, rst=1): all counters, snapshot, ovf, dwell counter, auto index, disp_data, disp_chan and the freeze edge register go to 0.
- Counting: cnt[i] increments when step && evt[i], one clk after the strobe.
- Overflow, Saturate=0: all-ones increments to 0 and sets ovf[i].
- Overflow, Saturate=1: all-ones holds and sets ovf[i].
- ovf[i] remains 1 until clr or rst.
- clr has priority over increment. In the clr cycle, counters, ovf and snapshot become 0.
- clr leaves the auto index and dwell counter unchanged.
- Freeze detection: freeze_q is registered. A rising edge (freeze && !freeze_q) copies all counters into the snapshot bank in that cycle.
- The copy takes the pre-increment values of that cycle.
- If clr and the freeze rising edge coincide, the snapshot becomes 0.
- Counters keep counting while frozen.
- Display source: snapshot[ch] while freeze=1, otherwise cnt[ch].
- Channel, manual (mode_auto=0): ch = sel if sel < NumChan, else 0. The dwell counter is held at 0 and the auto index is loaded with ch.
- Channel, auto (mode_auto=1): the dwell counter counts 0..DwellCnt-1. At terminal count it returns to 0 and the auto index advances, wrapping NumChan-1 -> 0. ch = auto index.
- Switching manual -> auto starts rotation from the last manual channel, with a full dwell period.
- Latency: disp_data and disp_chan are registered, one clk after a change of source or channel.
- An increment at clk edge k is visible on disp_data at edge k+1.
- No state machine beyond the dwell counter and the freeze edge register. All logic is in the clk domain; inputs are already synchronous to clk.

Decomposition:
- Shared package/header: Saturate mode constants (AUX_CNT_WRAP = 0, AUX_CNT_SAT = 1), the channel-index width macro, and channel assignments (CYC = 0, JMP = 1, BCH = 2, BED = 3, remaining channels reserved for new core events).
- Sub-module aux_event_counter (parameters CntBit, Saturate; ports clk, rst, clr, inc, cnt, ovf), instantiated NumChan times in a generate loop.
- Snapshot, channel selection and output registers stay in the top of this block.

Test Plan:
- Counting on strobes only: NumChan=4, CntBit=4. Hold evt=4'b0001, pulse step 5 times with 3 idle clks between pulses -> cnt[0]=5, other channels 0, disp_data=5 with sel=0.
- Wrap vs saturate: with Saturate=0, 17 steps on ch1 -> value 1, ovf=4'b0010. With Saturate=1, same stimulus -> value 15, ovf[1]=1.
- Freeze: ch0=7, raise freeze, apply 3 more steps -> disp_data stays 7 while cnt[0]=10. Drop freeze -> disp_data=10 one clk later.
- clr priority: clr and step with evt[0]=1 in the same cycle -> cnt[0]=0, ovf=0. Clr coincident with freeze rising edge -> snapshot 0, disp_data=0.
- Auto rotate: DwellCnt=3, mode_auto rises with sel=2 -> disp_chan sequence 2,2,2,3,3,3,0,0,0,1. sel=5 in manual mode -> disp_chan=0.
- Async reset mid-count: assert rst between clk edges -> all outputs 0 immediately. After release, counting resumes from 0.

Source files
------------

// File: rtl/aux_perf_monitor_pkg.sv
// Shared constants for the auxiliary performance monitor: counter overflow modes,
// core event channel assignments and an index-width helper.
// No logic, no latency, no backpressure.
package aux_perf_monitor_pkg;

  // Counter overflow behaviour (Saturate parameter values).
  localparam int AUX_CNT_WRAP = 0;  // all-ones increments to zero
  localparam int AUX_CNT_SAT  = 1;  // all-ones holds

  // Core event channel assignments. Channels 4 and up are reserved for new core events.
  localparam int AUX_CH_CYC = 0;  // core cycles
  localparam int AUX_CH_JMP = 1;  // jumps taken
  localparam int AUX_CH_BCH = 2;  // branches
  localparam int AUX_CH_BED = 3;  // branch end / mispredict

  // Width of an index able to address n entries. Never returns less than 1,
  // so a degenerate one-entry range still gets a real register.
  function automatic int aux_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aux_event_counter.sv
// One event counter with a sticky overflow flag and a selectable wrap/saturate mode.
// Latency: cnt and ovf update on the clk edge where inc is sampled high.
// Backpressure: none; every inc pulse is counted, and clr wins over inc.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear of count and overflow flag
//   inc       - count enable for this cycle
//   cnt       - current count
//   ovf       - sticky overflow flag, cleared only by clr or rst
module aux_event_counter
  import aux_perf_monitor_pkg::*;
#(
  parameter int CntBit   = 32,
  parameter int Saturate = AUX_CNT_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [CntBit-1:0] cnt,
  output logic              ovf
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        // Overflow is flagged in both modes; only the count value differs.
        ovf <= 1'b1;
        if (Saturate != AUX_CNT_SAT) begin
          cnt <= '0;
        end
      end else begin
        cnt <= cnt + CntBit'(1);
      end
    end
  end

endmodule

// File: rtl/aux_perf_monitor.sv
// Event-counter bank with snapshot freeze and a manual/auto-rotating display selector.
// Latency: counters update one clk after a step strobe; disp_data/disp_chan are registered (+1 clk).
// Backpressure: none; events are sampled only on step strobes and never stalled.
//
// Ports:
//   clk, rst   - board clock, asynchronous active-high reset
//   step       - one-clk pulse marking a core clock edge
//   evt        - per-channel event levels, counted only when step is high
//   clr        - synchronous clear of counters, overflow flags and snapshot
//   freeze     - level; while high the display shows the snapshot taken on its rising edge
//   mode_auto  - 1 = rotate display channel every DwellCnt clks, 0 = manual select
//   sel        - manual channel select (out-of-range values select channel 0)
//   disp_data  - registered value of the displayed channel
//   disp_chan  - registered index of the displayed channel
//   ovf        - sticky per-channel overflow flags
module aux_perf_monitor
  import aux_perf_monitor_pkg::*;
#(
  parameter int NumChan  = 8,
  parameter int CntBit   = 32,
  parameter int SelBit   = 4,
  parameter int DwellCnt = 1000,
  parameter int Saturate = AUX_CNT_WRAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic [NumChan-1:0] evt,
  input  logic               clr,
  input  logic               freeze,
  input  logic               mode_auto,
  input  logic [SelBit-1:0]  sel,
  output logic [CntBit-1:0]  disp_data,
  output logic [SelBit-1:0]  disp_chan,
  output logic [NumChan-1:0] ovf
);

  localparam int                DwBit     = aux_idx_bits(DwellCnt);
  localparam logic [DwBit-1:0]  DwellLast = DwBit'(DwellCnt - 1);
  localparam logic [SelBit-1:0] ChanLast  = SelBit'(NumChan - 1);

  logic [CntBit-1:0]  cnt_q   [NumChan];
  logic [CntBit-1:0]  snap_q  [NumChan];
  logic [NumChan-1:0] inc;
  logic               freeze_q;
  logic               frz_rise;
  logic [DwBit-1:0]   dwell_q;
  logic [SelBit-1:0]  auto_idx_q;
  logic [SelBit-1:0]  manual_ch;
  logic [SelBit-1:0]  ch;
  logic [CntBit-1:0]  cnt_sel;
  logic [CntBit-1:0]  snap_sel;

  // Only core-step strobes count, so a core cycle counts once whatever the clock ratio.
  assign inc = evt & {NumChan{step}};

  for (genvar g = 0; g < NumChan; g++) begin : g_cnt
    aux_event_counter #(
      .CntBit   (CntBit),
      .Saturate (Saturate)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc[g]),
      .cnt (cnt_q[g]),
      .ovf (ovf[g])
    );
  end

  // Freeze edge detection and snapshot bank.
  assign frz_rise = freeze & ~freeze_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_q <= 1'b0;
    end else begin
      freeze_q <= freeze;
    end
  end

  // The snapshot copies the registered counter values, i.e. the pre-increment
  // values of the rising-edge cycle. clr wins over a coincident rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumChan; i++) snap_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NumChan; i++) snap_q[i] <= '0;
    end else if (frz_rise) begin
      for (int i = 0; i < NumChan; i++) snap_q[i] <= cnt_q[i];
    end
  end

  // Channel selection.
  always_comb begin
    manual_ch = '0;
    if (int'(sel) < NumChan) begin
      manual_ch = sel;
    end
  end

  assign ch = mode_auto ? auto_idx_q : manual_ch;

  // In manual mode the auto index tracks the manual channel and the dwell counter
  // sits at zero, so entering auto mode starts from that channel with a full dwell.
  // clr deliberately does not touch this state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q    <= '0;
      auto_idx_q <= '0;
    end else if (!mode_auto) begin
      dwell_q    <= '0;
      auto_idx_q <= manual_ch;
    end else if (dwell_q == DwellLast) begin
      dwell_q    <= '0;
      auto_idx_q <= (auto_idx_q == ChanLast) ? '0 : auto_idx_q + SelBit'(1);
    end else begin
      dwell_q    <= dwell_q + DwBit'(1);
    end
  end

  // Display mux. Written as a compare loop so ch may be wider than the channel
  // index without ever addressing beyond the bank.
  always_comb begin
    cnt_sel  = '0;
    snap_sel = '0;
    for (int i = 0; i < NumChan; i++) begin
      if (ch == SelBit'(i)) begin
        cnt_sel  = cnt_q[i];
        snap_sel = snap_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data <= '0;
      disp_chan <= '0;
    end else begin
      disp_data <= freeze ? snap_sel : cnt_sel;
      disp_chan <= ch;
    end
  end

endmodule
